// File: rtl/ucsbece154b_mem_arbiter.sv
// Two-requester block-read arbiter: I-cache and D-cache misses share one
// burst-read memory port; one block transfer at a time, round-robin on ties.
module ucsbece154b_mem_arbiter #(
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  IReadRequest,
  input  logic [ADDR_WIDTH-1:0] IReadAddress,
  output logic [DATA_WIDTH-1:0] IDataIn,
  output logic                  IDataReady,
  output logic                  IGrant,
  input  logic                  DReadRequest,
  input  logic [ADDR_WIDTH-1:0] DReadAddress,
  output logic [DATA_WIDTH-1:0] DDataIn,
  output logic                  DDataReady,
  output logic                  DGrant,
  output logic                  MemReadRequest,
  output logic [ADDR_WIDTH-1:0] MemReadAddress,
  input  logic [DATA_WIDTH-1:0] MemDataIn,
  input  logic                  MemDataReady,
  output logic                  Busy,
  output logic                  SpuriousBeat
);

  localparam int unsigned CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int unsigned OFF_W = CNT_W + 2;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Owner / last-grant encoding
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  igrant_d, dgrant_d, mem_req_d, busy_d, spurious_d;
  logic                  pick;
  logic                  beat_c;

  // Beats are only accepted while a burst is in flight
  assign beat_c = (state_q == S_BURST) && MemDataReady;

  // Same-cycle steering of an accepted beat to the current owner only
  assign IDataReady = beat_c && (owner_q == OWN_I);
  assign DDataReady = beat_c && (owner_q == OWN_D);
  assign IDataIn    = IDataReady ? MemDataIn : '0;
  assign DDataIn    = DDataReady ? MemDataIn : '0;

  // State and registered-output register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= S_IDLE;
      owner_q        <= OWN_I;
      last_grant_q   <= OWN_D;
      beat_cnt_q     <= '0;
      MemReadAddress <= '0;
      IGrant         <= 1'b0;
      DGrant         <= 1'b0;
      MemReadRequest <= 1'b0;
      Busy           <= 1'b0;
      SpuriousBeat   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      beat_cnt_q     <= beat_cnt_d;
      MemReadAddress <= mem_addr_d;
      IGrant         <= igrant_d;
      DGrant         <= dgrant_d;
      MemReadRequest <= mem_req_d;
      Busy           <= busy_d;
      SpuriousBeat   <= spurious_d;
    end
  end

  // Next-state and next registered-output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    mem_addr_d   = MemReadAddress;
    igrant_d     = IGrant;
    dgrant_d     = DGrant;
    mem_req_d    = 1'b0;
    pick         = OWN_I;
    spurious_d   = SpuriousBeat | (MemDataReady && (state_q != S_BURST));

    case (state_q)
      S_IDLE: begin
        if (IReadRequest || DReadRequest) begin
          // On a tie the requester that did not win last time goes first
          if (IReadRequest && DReadRequest) pick = ~last_grant_q;
          else                              pick = DReadRequest ? OWN_D : OWN_I;
          owner_d    = pick;
          mem_addr_d = ((pick == OWN_D) ? DReadAddress : IReadAddress) & ~OFF_MASK;
          igrant_d   = (pick == OWN_I);
          dgrant_d   = (pick == OWN_D);
          mem_req_d  = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        beat_cnt_d = '0;
        state_d    = S_BURST;
      end
      S_BURST: begin
        if (MemDataReady) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            igrant_d   = 1'b0;
            dgrant_d   = 1'b0;
            state_d    = S_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        // Requests ignored here so the finishing requester can drop its request
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule
